// File: rtl/samplerz_pkg.sv
// Shared types and constants for the samplerz BerExp exp-polynomial control path.
package samplerz_pkg;

  localparam int Z_W   = 64;  // z and shared subtractor width
  localparam int Y_W   = 63;  // for_loop word width
  localparam int S_MAX = 63;  // largest shift applied to 2y-1
  localparam int S_W   = 6;   // bits needed to hold 0..S_MAX

  typedef enum logic [2:0] {
    IDLE,
    POLY,
    SCALE,
    CMP,
    DONE
  } state_t;

  // Index of the z byte currently being compared (7 = most significant).
  typedef logic [2:0] byte_idx_t;

  // Shift amounts above S_MAX saturate to S_MAX.
  function automatic logic [S_W-1:0] clip_shift(input logic [6:0] s);
    return (s > 7'(S_MAX)) ? S_W'(S_MAX) : s[S_W-1:0];
  endfunction

endpackage

// File: rtl/ber_exp_ctrl_sub64.sv
// Shared 64-bit subtractor: purely combinational a - b, wrapping mod 2^64.
module sub64
  import samplerz_pkg::*;
(
  input  logic [Z_W-1:0] a,
  input  logic [Z_W-1:0] b,
  output logic [Z_W-1:0] diff
);

  assign diff = a - b;

endmodule

// File: rtl/ber_exp_ctrl.sv
// BerExp initiator: launches for_loop, lends it the shared subtractor, scales
// the result into z and runs the lazy byte-wise Bernoulli compare.
module ber_exp_ctrl
  import samplerz_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [62:0]   r_63,
  input  logic [62:0]   ccs_63,
  input  logic [6:0]    s_in,
  output logic          busy,
  output logic          done,
  output logic          accept,
  output logic          fl_valid,
  output logic [62:0]   fl_z_63,
  output logic [62:0]   fl_ccs_63,
  input  logic [62:0]   fl_y_63,
  input  logic          fl_done,
  input  logic [63:0]   fl_sub_data_in_a,
  input  logic [63:0]   fl_sub_data_in_b,
  input  logic          fl_sub_data_valid,
  output logic [62:0]   fl_sub_data_out,
  output logic          rnd_req,
  input  logic          rnd_valid,
  input  logic [7:0]    rnd_byte
);

  state_t          state_q, state_d;
  logic [Y_W-1:0]  r_q, r_d;
  logic [Y_W-1:0]  ccs_q, ccs_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [Z_W-1:0]  z_q, z_d;
  byte_idx_t       idx_q, idx_d;
  logic            accept_q, accept_d;

  logic [Z_W-1:0]  sub_a, sub_b, sub_diff;
  logic [7:0]      z_byte;

  // for_loop computes the same result whether or not it flags the request,
  // so the valid strobe carries no information for this side.
  logic unused_sub_valid;
  assign unused_sub_valid = fl_sub_data_valid;

  assign z_byte = z_q[{idx_q, 3'b000} +: 8];

  sub64 u_sub64 (
    .a    (sub_a),
    .b    (sub_b),
    .diff (sub_diff)
  );

  // Operand mux: for_loop owns the subtractor in POLY, this block otherwise.
  always_comb begin
    sub_a = '0;
    sub_b = '0;
    unique case (state_q)
      POLY: begin
        sub_a = fl_sub_data_in_a;
        sub_b = fl_sub_data_in_b;
      end
      SCALE: begin
        sub_a = {y_q, 1'b0};
        sub_b = Z_W'(1);
      end
      CMP: begin
        sub_a = {56'b0, rnd_byte};
        sub_b = {56'b0, z_byte};
      end
      default: ;
    endcase
  end

  // Next-state and datapath update; outputs are decoded from the current state.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    ccs_d     = ccs_q;
    s_d       = s_q;
    y_d       = y_q;
    z_d       = z_q;
    idx_d     = idx_q;
    accept_d  = accept_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = r_63;
          ccs_d   = ccs_63;
          s_d     = clip_shift(s_in);
          state_d = POLY;
        end
      end
      POLY: begin
        if (fl_done) begin
          y_d     = fl_y_63;
          state_d = SCALE;
        end
      end
      SCALE: begin
        // y = 0 deliberately wraps to all-ones before the shift.
        z_d     = sub_diff >> s_q;
        idx_d   = 3'd7;
        state_d = CMP;
      end
      CMP: begin
        if (rnd_valid) begin
          // A nonzero difference settles the compare; equal bytes defer to
          // the next less significant byte until the last one.
          if ((sub_diff != '0) || (idx_q == 3'd0)) begin
            accept_d = sub_diff[Z_W-1];
            state_d  = DONE;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_q      <= '0;
      ccs_q    <= '0;
      s_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      idx_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      ccs_q    <= ccs_d;
      s_q      <= s_d;
      y_q      <= y_d;
      z_q      <= z_d;
      idx_q    <= idx_d;
      accept_q <= accept_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign fl_valid        = (state_q == POLY);
  assign rnd_req         = (state_q == CMP);
  assign accept          = accept_q;
  assign fl_z_63         = r_q;
  assign fl_ccs_63       = ccs_q;
  assign fl_sub_data_out = (state_q == POLY) ? sub_diff[62:0] : 63'd0;

endmodule

// File: tb/tb_ber_exp_ctrl.sv
// Scoreboard bench for ber_exp_ctrl with a for_loop stub and a PRNG byte source.
module tb_ber_exp_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [62:0] r_63, ccs_63;
  logic [6:0]  s_in;
  logic        busy, done, accept, fl_valid;
  logic [62:0] fl_z_63, fl_ccs_63, fl_y_63;
  logic        fl_done;
  logic [63:0] fl_a, fl_b;
  logic        fl_sv;
  logic [62:0] fl_out;
  logic        rnd_req, rnd_valid;
  logic [7:0]  rnd_byte;

  ber_exp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .r_63(r_63), .ccs_63(ccs_63),
    .s_in(s_in), .busy(busy), .done(done), .accept(accept), .fl_valid(fl_valid),
    .fl_z_63(fl_z_63), .fl_ccs_63(fl_ccs_63), .fl_y_63(fl_y_63), .fl_done(fl_done),
    .fl_sub_data_in_a(fl_a), .fl_sub_data_in_b(fl_b), .fl_sub_data_valid(fl_sv),
    .fl_sub_data_out(fl_out), .rnd_req(rnd_req), .rnd_valid(rnd_valid),
    .rnd_byte(rnd_byte)
  );

  typedef struct {
    logic  acc;
    int    nbytes;
    string name;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] byte_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int stall_n  = 0;
  int bytes_used = 0;
  int done_cnt = 0;
  int fl_lat   = 3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // for_loop stub: pulses fl_done once, fl_lat cycles into each fl_valid window.
  initial begin
    int  cnt;
    bit  sent;
    cnt = 0; sent = 0; fl_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (fl_valid && !sent) begin
        if (cnt == fl_lat) begin fl_done = 1'b1; sent = 1; end
        else fl_done = 1'b0;
        cnt++;
      end else begin
        fl_done = 1'b0;
        if (!fl_valid) begin cnt = 0; sent = 0; end
      end
    end
  end

  // PRNG source: serves queued bytes while rnd_req is high, with optional stalls.
  initial begin
    int         stall_cnt;
    logic [7:0] used;
    stall_cnt = 0; rnd_valid = 1'b0; rnd_byte = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rnd_valid) begin used = byte_q.pop_front(); bytes_used++; end
      if (rnd_req && byte_q.size() > 0) begin
        if (stall_cnt < stall_n) begin rnd_valid = 1'b0; stall_cnt++; end
        else begin rnd_valid = 1'b1; rnd_byte = byte_q[0]; stall_cnt = 0; end
      end else begin
        rnd_valid = 1'b0;
      end
    end
  end

  // Monitor: every done pops one expected result and checks it.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_one_cycle", {63'd0, prev_done}, 64'd0);
        done_cnt++;
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no done");
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_accept"}, {63'd0, accept}, {63'd0, e.acc});
          check({e.name, "_bytes"}, 64'(bytes_used), 64'(e.nbytes));
          $display("txn %s: accept=%0d bytes=%0d", e.name, accept, bytes_used);
        end
      end
      prev_done = done;
    end
  end

  task automatic kick(input logic [62:0] y, input logic [6:0] s, input logic [62:0] r);
    @(posedge clk); #1;
    fl_y_63 = y; s_in = s; r_63 = r; ccs_63 = ~r; bytes_used = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int  base;
    bit  seen;
    base = done_cnt; seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done_cnt > base) begin seen = 1; break; end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic push_txn(input string name, input logic acc, input int nb);
    exp_t e;
    e.name = name; e.acc = acc; e.nbytes = nb;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_fl_valid", {63'd0, fl_valid}, 64'd0);
    check("rst_rnd_req", {63'd0, rnd_req}, 64'd0);
    check("rst_accept", {63'd0, accept}, 64'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; r_63 = '0; ccs_63 = '0; s_in = '0;
    fl_y_63 = '0; fl_sv = 1'b0;
    fl_a = 64'h8000_0000_0000_0000; fl_b = 64'd1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_accept", {63'd0, accept}, 64'd0);
    check("reset_fl_valid", {63'd0, fl_valid}, 64'd0);
    check("reset_rnd_req", {63'd0, rnd_req}, 64'd0);
    check("reset_fl_z", {1'b0, fl_z_63}, 64'd0);
    check("idle_sub_out_gated", {1'b0, fl_out}, 64'd0);

    // T1: z=0x7FFF..FF, bytes 7F then 80 -> accept=1 after 2 bytes.
    byte_q = '{8'h7F, 8'h80};
    push_txn("t1", 1'b1, 2);
    kick(63'h4000_0000_0000_0000, 7'd0, 63'h0123_4567_89AB_CDEF);
    @(negedge clk);
    check("poly_fl_valid", {63'd0, fl_valid}, 64'd1);
    check("poly_busy", {63'd0, busy}, 64'd1);
    check("poly_sub_out", {1'b0, fl_out}, 64'h7FFF_FFFF_FFFF_FFFF);
    check("poly_fl_z", {1'b0, fl_z_63}, 64'h0123_4567_89AB_CDEF);
    check("poly_fl_ccs", {1'b0, fl_ccs_63}, {1'b0, ~63'h0123_4567_89AB_CDEF});
    @(posedge clk); #1; start = 1'b1;     // ignored: DUT is busy
    @(posedge clk); #1; start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fl_done) begin seen = 1; break; end
    end
    check("fl_done_seen", {63'd0, seen}, 64'd1);
    check("fl_valid_at_done", {63'd0, fl_valid}, 64'd1);
    @(negedge clk);
    check("fl_valid_dropped", {63'd0, fl_valid}, 64'd0);
    check("scale_sub_out_gated", {1'b0, fl_out}, 64'd0);
    wait_done("t1", 50);
    repeat (3) @(negedge clk);
    check("t1_accept_held", {63'd0, accept}, 64'd1);

    // T2: same z, first byte 0x80 -> w=+1, accept=0 after 1 byte.
    byte_q = '{8'h80};
    push_txn("t2", 1'b0, 1);
    kick(63'h4000_0000_0000_0000, 7'd0, 63'd5);
    wait_done("t2", 50);

    // T3: s_in=100 clips to 63 -> z=1; eight 0x00 -> accept=1.
    fl_a = 64'd5; fl_b = 64'd7;
    byte_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_txn("t3", 1'b1, 8);
    kick(63'h7FFF_FFFF_FFFF_FFFF, 7'd100, 63'd9);
    @(negedge clk);
    check("poly_sub_wrap", {1'b0, fl_out}, 64'h7FFF_FFFF_FFFF_FFFE);
    wait_done("t3", 60);

    // T4: z=1; seven 0x00 then 0x01 -> w=0 at last byte, accept=0.
    byte_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    push_txn("t4", 1'b0, 8);
    kick(63'h7FFF_FFFF_FFFF_FFFF, 7'd100, 63'd9);
    wait_done("t4", 60);

    // T5: T1 again with 5-cycle PRNG stalls -> same result, rnd_req held.
    stall_n = 5;
    byte_q = '{8'h7F, 8'h80};
    push_txn("t5", 1'b1, 2);
    kick(63'h4000_0000_0000_0000, 7'd0, 63'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rnd_req) begin seen = 1; break; end
    end
    check("t5_rnd_req_seen", {63'd0, seen}, 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("t5_rnd_req_held", {63'd0, rnd_req}, 64'd1);
    end
    wait_done("t5", 80);
    stall_n = 0;

    // Reset mid-POLY: for_loop never finishes, reset returns to IDLE, no done.
    fl_lat = 1000;
    kick(63'd3, 7'd0, 63'd3);
    repeat (3) @(negedge clk);
    check("midpoly_fl_valid", {63'd0, fl_valid}, 64'd1);
    do_reset();
    repeat (5) @(negedge clk);

    // Reset mid-CMP: no PRNG bytes available, reset while waiting.
    fl_lat = 2;
    byte_q.delete();
    kick(63'h4000_0000_0000_0000, 7'd0, 63'd4);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rnd_req) begin seen = 1; break; end
    end
    check("midcmp_rnd_req", {63'd0, seen}, 64'd1);
    do_reset();
    repeat (5) @(negedge clk);

    // Fresh transaction after resets completes normally.
    byte_q = '{8'h80};
    push_txn("t6", 1'b0, 1);
    kick(63'h4000_0000_0000_0000, 7'd0, 63'd6);
    wait_done("t6", 50);
    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
